// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: address/instruction widths, reset PC and FSM states.
package core_pkg;
  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: sequential +4 advance with redirect taking priority.
module if_pc_reg #(
  parameter int WIDTH = core_pkg::XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);
  // Increment wraps modulo 2^WIDTH by plain truncation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + WIDTH'(4);
    end
  end
endmodule

// File: rtl/if_fetch.sv
// RV64 instruction-fetch stage: one outstanding imem request, output register plus skid.
// Optional misaligned-redirect trap/stall enabled by IF_FETCH_MISALIGN_CHK_EN.
module if_fetch #(
  parameter int XLEN = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [core_pkg::INST_W-1:0] imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [core_pkg::INST_W-1:0] id_inst,
  output logic                       fetch_misalign
);
  import core_pkg::*;

  fetch_state_e state, state_next;
  logic [XLEN-1:0] pc, req_pc, skid_pc, redirect_target;
  logic [INST_W-1:0] skid_inst;
  logic drop, drop_next, misalign;
  logic req_fire, out_free, load_rsp, load_skid, skid_to_out;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  assign redirect_target = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (redirect_valid) begin
      misalign <= |redirect_pc[1:0];
    end
  end
`else
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign misalign = 1'b0;
`endif

  assign fetch_misalign = misalign;
  assign out_free       = !id_valid || id_ready;
  assign imem_req_valid = (state == REQ) && !redirect_valid && out_free && !misalign;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  if_pc_reg #(.WIDTH(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (req_fire),
    .redirect (redirect_valid),
    .target   (redirect_target),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (req_fire) req_pc <= pc;
    end
  end

  // A redirect beats every other event; a response still owed to imem becomes a drop.
  always_comb begin
    state_next  = state;
    drop_next   = drop;
    load_rsp    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (redirect_valid) begin
      state_next = REQ;
      if (state == WAIT) begin
        if (imem_rsp_valid) begin
          drop_next = 1'b0;
        end else begin
          drop_next  = 1'b1;
          state_next = WAIT;
        end
      end
    end else begin
      case (state)
        BOOT: state_next = REQ;
        REQ:  if (req_fire) state_next = WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            state_next = REQ;
            if (drop) begin
              drop_next = 1'b0;
            end else if (out_free) begin
              load_rsp = 1'b1;
            end else begin
              load_skid  = 1'b1;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_ready) begin
            skid_to_out = 1'b1;
            state_next  = REQ;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_inst   <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else if (redirect_valid) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_inst   <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else begin
      if (load_rsp) begin
        id_valid <= 1'b1;
        id_pc    <= req_pc;
        id_inst  <= imem_rsp_data;
      end else if (skid_to_out) begin
        id_valid <= 1'b1;
        id_pc    <= skid_pc;
        id_inst  <= skid_inst;
      end else if (id_ready) begin
        id_valid <= 1'b0;
      end
      if (load_skid) begin
        skid_pc   <= req_pc;
        skid_inst <= imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: instruction-stream reference model plus directed scenarios.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        fetch_misalign;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_req_pc = 64'h0;
  logic [63:0] exp_id_pc = 64'h0;
  bit          exp_mis = 1'b0;
  bit          outstanding = 1'b0;
  int          rsp_cnt = 0;
  logic [63:0] rsp_addr = 64'h0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_pc;
  logic [31:0] prev_inst;
  bit          obs_req_fire, obs_id_fire;
  int          delivered = 0;
  logic [63:0] req_log[$];
  logic [63:0] id_log[$];

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .fetch_misalign (fetch_misalign)
  );

  // Memory image: every address holds a word derived from the address itself.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] redirect_dest(input logic [63:0] t);
`ifdef IF_FETCH_MISALIGN_CHK_EN
    return t;
`else
    return {t[63:2], 2'b00};
`endif
  endfunction

  function automatic logic [63:0] log_at(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s miscompare", tag);
    end
  endtask

  // Stream-level model: presented/delivered PCs and request addresses run sequentially from the last redirect.
  task automatic checkOutput(input int lat);
    obs_req_fire = imem_req_valid && imem_req_ready;
    obs_id_fire  = id_valid && id_ready;
    if (prev_hold) begin
      compare("hold_valid", {63'b0, id_valid}, 64'd1);
      compare("hold_pc", id_pc, prev_pc);
      compare("hold_inst", {32'b0, id_inst}, {32'b0, prev_inst});
    end
    if (redirect_valid) compare("redirect_gates_req", {63'b0, imem_req_valid}, 64'd0);
    if (outstanding) compare("one_outstanding", {63'b0, imem_req_valid}, 64'd0);
    if (exp_mis) begin
      compare("mis_no_req", {63'b0, imem_req_valid}, 64'd0);
      compare("mis_no_id", {63'b0, id_valid}, 64'd0);
    end
    compare("fetch_misalign", {63'b0, fetch_misalign}, {63'b0, exp_mis});
    if (obs_req_fire) begin
      compare("req_addr", imem_req_addr, exp_req_pc);
      req_log.push_back(imem_req_addr);
      exp_req_pc  = exp_req_pc + 64'd4;
      outstanding = 1'b1;
      rsp_cnt     = lat;
      rsp_addr    = imem_req_addr;
    end
    if (id_valid) begin
      compare("id_pc", id_pc, exp_id_pc);
      compare("id_inst", {32'b0, id_inst}, {32'b0, mem_word(exp_id_pc)});
    end
    if (obs_id_fire) begin
      id_log.push_back(id_pc);
      exp_id_pc = exp_id_pc + 64'd4;
      delivered++;
    end
    prev_hold = id_valid && !id_ready && !redirect_valid;
    prev_pc   = id_pc;
    prev_inst = id_inst;
    if (redirect_valid) begin
      exp_req_pc = redirect_dest(redirect_pc);
      exp_id_pc  = redirect_dest(redirect_pc);
`ifdef IF_FETCH_MISALIGN_CHK_EN
      exp_mis = |redirect_pc[1:0];
`endif
    end
  endtask

  // One clock cycle: drive imem response and inputs after the falling edge, then check.
  task automatic applyStimulus(input bit req_rdy, input int lat, input bit idr,
                               input bit redir, input logic [63:0] tgt);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (outstanding) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(rsp_addr);
        outstanding    = 1'b0;
      end
    end
    imem_req_ready = req_rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : {$urandom, $urandom};
    #1;
    checkOutput(lat);
  endtask

  task automatic clear_logs();
    req_log.delete();
    id_log.delete();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  first_valid;
    bit  found;
    logic [63:0] tgt;

    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    id_ready       = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    compare("rst_id_valid", {63'b0, id_valid}, 64'd0);
    compare("rst_id_pc", id_pc, 64'd0);
    compare("rst_id_inst", {32'b0, id_inst}, 64'd0);
    compare("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    compare("rst_misalign", {63'b0, fetch_misalign}, 64'd0);
    compare("rst_req_addr", imem_req_addr, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare("boot_req_valid", {63'b0, imem_req_valid}, 64'd0);

    // Sequential fetch from reset with single-cycle imem.
    first_valid = -1;
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
      if (id_valid && first_valid < 0) first_valid = c;
    end
    compare("first_valid_cycle", 64'(first_valid), 64'd3);
    compare("t1_req0", log_at(req_log, 0), 64'h0);
    compare("t1_req1", log_at(req_log, 1), 64'h4);
    compare("t1_req2", log_at(req_log, 2), 64'h8);
    compare("t1_id0", log_at(id_log, 0), 64'h0);
    compare("t1_id1", log_at(id_log, 1), 64'h4);

    // Decode stalls: no further requests while the presented word is not taken.
    applyStimulus(1'b1, 1, 1'b0, 1'b1, 64'h0);
    clear_logs();
    repeat (6) applyStimulus(1'b1, 1, 1'b0, 1'b0, 64'h0);
    compare("t2_req_count", 64'(req_log.size()), 64'd1);
    compare("t2_id_count", 64'(id_log.size()), 64'd0);
    repeat (4) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
    compare("t2_id0", log_at(id_log, 0), 64'h0);
    compare("t2_id1", log_at(id_log, 1), 64'h4);
    compare("t2_id_count_after", 64'(id_log.size()), 64'd2);

    // Redirect while a slow response is still owed.
    obs_req_fire = 1'b0;
    for (int i = 0; i < 10 && !obs_req_fire; i++) applyStimulus(1'b1, 3, 1'b1, 1'b0, 64'h0);
    compare("t3_fire_seen", {63'b0, obs_req_fire}, 64'd1);
    applyStimulus(1'b1, 3, 1'b1, 1'b1, 64'h8000_0000);
    clear_logs();
    repeat (10) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
    compare("t3_req0", log_at(req_log, 0), 64'h8000_0000);
    compare("t3_id0", log_at(id_log, 0), 64'h8000_0000);

    // Redirect landing on the very cycle the response returns.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(1'b1, 2, 1'b1, 1'b0, 64'h0);
      if (outstanding && rsp_cnt == 1) found = 1'b1;
    end
    compare("t4_rsp_pending", {63'b0, found}, 64'd1);
    applyStimulus(1'b1, 1, 1'b1, 1'b1, 64'h4000);
    clear_logs();
    repeat (8) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
    compare("t4_id0", log_at(id_log, 0), 64'h4000);

    // Redirect while a word is being presented and not accepted.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(1'b1, 1, 1'b0, 1'b0, 64'h0);
      if (id_valid) found = 1'b1;
    end
    compare("t4b_id_valid_seen", {63'b0, found}, 64'd1);
    applyStimulus(1'b1, 1, 1'b0, 1'b1, 64'h5000);
    clear_logs();
    repeat (8) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
    compare("t4b_id0", log_at(id_log, 0), 64'h5000);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    clear_logs();
    repeat (8) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
    compare("t5_req0", log_at(req_log, 0), 64'hFFFF_FFFF_FFFF_FFFC);
    compare("t5_req1", log_at(req_log, 1), 64'h0);
    compare("t5_id1", log_at(id_log, 1), 64'h0);

    // Misaligned redirect target.
    applyStimulus(1'b1, 1, 1'b1, 1'b1, 64'h102);
    clear_logs();
    repeat (8) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
`ifdef IF_FETCH_MISALIGN_CHK_EN
    compare("t6_misalign", {63'b0, fetch_misalign}, 64'd1);
    compare("t6_no_req", 64'(req_log.size()), 64'd0);
    applyStimulus(1'b1, 1, 1'b1, 1'b1, 64'h300);
    clear_logs();
    repeat (6) applyStimulus(1'b1, 1, 1'b1, 1'b0, 64'h0);
    compare("t6_cleared", {63'b0, fetch_misalign}, 64'd0);
    compare("t6_resume", log_at(req_log, 0), 64'h300);
`else
    compare("t6_req0", log_at(req_log, 0), 64'h100);
    compare("t6_id0", log_at(id_log, 0), 64'h100);
`endif

    // Randomized traffic against the stream model.
    delivered = 0;
    for (int c = 0; c < 600; c++) begin
      tgt = {$urandom, $urandom};
      tgt[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(1, 3)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, tgt);
    end
    compare("random_progress", {63'b0, (delivered > 20)}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
